// File: rtl/time_set_ctrl.sv
// Button-driven HH:MM set controller: MODE walks the digits, INC does a read-modify-write on the timer bus.
// Optional build macro TSC_AUTOREPEAT_EN adds INC auto-repeat while the button is held.
module time_set_ctrl #(
    parameter int          DEB_CYCLES    = 1000000,
    parameter int          BLINK_CYCLES  = 12500000,
    parameter int          REPEAT_CYCLES = 25000000,
    parameter logic [10:0] ADDR_MIN0     = 11'h400,
    parameter logic [10:0] ADDR_MIN1     = 11'h401,
    parameter logic [10:0] ADDR_HOUR0    = 11'h402,
    parameter logic [10:0] ADDR_HOUR1    = 11'h403
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic        t_sel,
    output logic [10:0] t_address,
    output logic [3:0]  t_wdata,
    output logic        t_write_en,
    input  logic [3:0]  t_rdata,
    output logic        editing,
    output logic [3:0]  blink_mask
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [2:0] {RUN, E_H1, E_H0, E_M1, E_M0} mode_t;
    typedef enum logic [2:0] {A_IDLE, A_ADDR, A_WAIT, A_CAP, A_WR} acc_t;

    mode_t         state;
    acc_t          acc;
    logic          mode_pend;
    logic          auto_rd;
    logic [3:0]    hour1_q;
    logic          blink_phase;
    logic [BW-1:0] blink_cnt;

    // Bit 0 = MODE, bit 1 = INC.
    logic [1:0]    sync1, sync2, level, press;
    logic [DW-1:0] deb_cnt [2];

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_inc, btn_mode};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                    press[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic inc_req;
`ifdef TSC_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    // Hold time only accrues while the bus is idle, so a repeat never collides with an access.
    assign rep_fire = level[1] && (state != RUN) && (acc == A_IDLE) && (rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (rst || !level[1] || press[0]) begin
            rep_cnt <= '0;
        end else if (acc == A_IDLE && state != RUN) begin
            rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
        end
    end

    assign inc_req = press[1] | rep_fire;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign inc_req = press[1];
`endif

    function automatic logic [10:0] digit_addr(input mode_t s);
        case (s)
            E_H1:    return ADDR_HOUR1;
            E_H0:    return ADDR_HOUR0;
            E_M1:    return ADDR_MIN1;
            default: return ADDR_MIN0;
        endcase
    endfunction

    function automatic logic [3:0] digit_onehot(input mode_t s);
        case (s)
            E_H1:    return 4'b1000;
            E_H0:    return 4'b0100;
            E_M1:    return 4'b0010;
            E_M0:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] digit_limit(input mode_t s, input logic [3:0] h1);
        case (s)
            E_H1:    return 4'd2;
            E_H0:    return (h1 == 4'd2) ? 4'd3 : 4'd9;
            E_M1:    return 4'd5;
            default: return 4'd9;
        endcase
    endfunction

    logic [3:0] next_val;
    assign next_val = (t_rdata >= digit_limit(state, hour1_q)) ? 4'd0 : t_rdata + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            acc         <= A_IDLE;
            mode_pend   <= 1'b0;
            auto_rd     <= 1'b0;
            hour1_q     <= 4'd0;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
            t_sel       <= 1'b0;
            t_address   <= ADDR_MIN0;
            t_wdata     <= 4'd0;
            t_write_en  <= 1'b0;
            editing     <= 1'b0;
            blink_mask  <= 4'd0;
        end else begin
            editing    <= (state != RUN);
            blink_mask <= digit_onehot(state) & {4{blink_phase}};

            if (state == RUN) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            case (acc)
                A_IDLE: begin
                    if (state != RUN && inc_req) begin
                        acc       <= A_ADDR;
                        auto_rd   <= 1'b0;
                        t_sel     <= 1'b1;
                        t_address <= digit_addr(state);
                        if (press[0]) mode_pend <= 1'b1;
                    end else if (press[0] || mode_pend) begin
                        // Digit change: restart the blink with the digit visible.
                        mode_pend   <= 1'b0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b1;
                        case (state)
                            RUN:  state <= E_H1;
                            E_H1: begin
                                // HOUR0's limit depends on HOUR1, so refresh the cache on entry.
                                state     <= E_H0;
                                acc       <= A_ADDR;
                                auto_rd   <= 1'b1;
                                t_sel     <= 1'b1;
                                t_address <= ADDR_HOUR1;
                            end
                            E_H0:    state <= E_M1;
                            E_M1:    state <= E_M0;
                            default: state <= RUN;
                        endcase
                    end
                end
                A_ADDR: acc <= A_WAIT;
                A_WAIT: acc <= A_CAP;
                A_CAP: begin
                    if (auto_rd) begin
                        hour1_q <= t_rdata;
                        auto_rd <= 1'b0;
                        t_sel   <= 1'b0;
                        acc     <= A_IDLE;
                    end else begin
                        t_wdata    <= next_val;
                        t_write_en <= 1'b1;
                        acc        <= A_WR;
                        if (state == E_H1) hour1_q <= next_val;
                    end
                end
                A_WR: begin
                    t_write_en <= 1'b0;
                    t_sel      <= 1'b0;
                    acc        <= A_IDLE;
                end
                default: acc <= A_IDLE;
            endcase

            if (press[0] && acc != A_IDLE) mode_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a registered-read model of the HH:MM timer bus.
// Expectations for the INC hold test depend on TSC_AUTOREPEAT_EN.
module tb_time_set_ctrl;

    localparam logic [10:0] A_M0 = 11'h400;
    localparam logic [10:0] A_M1 = 11'h401;
    localparam logic [10:0] A_H0 = 11'h402;
    localparam logic [10:0] A_H1 = 11'h403;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        t_sel;
    logic [10:0] t_address;
    logic [3:0]  t_wdata;
    logic        t_write_en;
    logic [3:0]  t_rdata;
    logic        editing;
    logic [3:0]  blink_mask;

    int n_vec = 0;
    int n_bad = 0;

    time_set_ctrl #(
        .DEB_CYCLES(4), .BLINK_CYCLES(8), .REPEAT_CYCLES(20),
        .ADDR_MIN0(A_M0), .ADDR_MIN1(A_M1), .ADDR_HOUR0(A_H0), .ADDR_HOUR1(A_H1)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .t_sel(t_sel), .t_address(t_address), .t_wdata(t_wdata), .t_write_en(t_write_en),
        .t_rdata(t_rdata), .editing(editing), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    // Timer model: index 0=MIN0, 1=MIN1, 2=HOUR0, 3=HOUR1; read data registered.
    logic [3:0]  tmem [4];
    logic        pl_en = 1'b0;
    logic [1:0]  pl_idx = 2'd0;
    logic [3:0]  pl_val = 4'd0;
    int          wr_count = 0;
    logic [10:0] last_waddr = '0;
    logic [3:0]  last_wdata = '0;
    logic [3:0]  wr_hist [8];

    always @(posedge clk) begin
        t_rdata <= tmem[t_address[1:0]];
        if (pl_en) tmem[pl_idx] <= pl_val;
        if (t_sel && t_write_en) begin
            tmem[t_address[1:0]]  <= t_wdata;
            wr_hist[wr_count % 8] <= t_wdata;
            wr_count   <= wr_count + 1;
            last_waddr <= t_address;
            last_wdata <= t_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [3:0] val);
        @(negedge clk);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic press_btn(input logic m, input logic i, input int hold);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic mode_step(input int n);
        for (int k = 0; k < n; k++) begin
            press_btn(1'b1, 1'b0, 6);
            repeat (12) @(negedge clk);
        end
    endtask

    // Raw INC (optionally with MODE) goes high just after a negedge; n counts later negedges.
    // Sync (2) + debounce (4) puts the press pulse after edge 6, so the strobe shows at n=10.
    task automatic inc_timed(input logic with_mode, input int hold, input int rst_at,
                             output int lat, output int nwr, output logic [3:0] mask_snap);
        int w0;
        w0  = wr_count;
        lat = -1;
        mask_snap = 4'hx;
        @(negedge clk);
        btn_inc  = 1'b1;
        btn_mode = with_mode;
        for (int n = 1; n <= hold + 40; n++) begin
            @(negedge clk);
            if (n == hold) begin
                btn_inc  = 1'b0;
                btn_mode = 1'b0;
            end
            if (n == rst_at) rst = 1'b1;
            else if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
            if (n == hold + 8) mask_snap = blink_mask;
            if (t_write_en && lat < 0) lat = n;
        end
        nwr = wr_count - w0;
    endtask

    initial begin
        int lat, nwr, w0;
        logic [3:0] msk;
        logic saw_sel, saw_we, saw_ed, found;

        repeat (3) @(negedge clk);
        check("rst_t_sel", t_sel, 1'b0);
        check("rst_t_write_en", t_write_en, 1'b0);
        check("rst_t_wdata", t_wdata, 4'd0);
        check("rst_t_address", t_address, A_M0);
        check("rst_editing", editing, 1'b0);
        check("rst_blink_mask", blink_mask, 4'd0);
        rst = 1'b0;

        saw_sel = 1'b0; saw_we = 1'b0; saw_ed = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            saw_sel |= t_sel;
            saw_we  |= t_write_en;
            saw_ed  |= editing | (|blink_mask);
        end
        check("idle_t_sel", saw_sel, 1'b0);
        check("idle_t_write_en", saw_we, 1'b0);
        check("idle_editing", saw_ed, 1'b0);

        preload(2'd3, 4'd2);
        preload(2'd2, 4'd7);
        preload(2'd1, 4'd4);
        preload(2'd0, 4'd9);

        press_btn(1'b1, 1'b0, 3);
        repeat (10) @(negedge clk);
        check("bounce_editing", editing, 1'b0);

        press_btn(1'b1, 1'b0, 6);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (editing) begin
                found = 1'b1;
                break;
            end
        end
        check("enter_edit", found, 1'b1);
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || i == 7 || i == 8 || i == 15 || i == 16 || i == 23)
                check($sformatf("blink_%0d", i), blink_mask, (i < 8 || i >= 16) ? 4'b1000 : 4'b0000);
            @(negedge clk);
        end

        mode_step(3);
        inc_timed(1'b0, 6, -1, lat, nwr, msk);
        check("m0_latency", lat, 10);
        check("m0_one_write", nwr, 1);
        check("m0_addr", last_waddr, A_M0);
        check("m0_wrap9", last_wdata, 4'd0);
        preload(2'd0, 4'd4);
        inc_timed(1'b0, 6, -1, lat, nwr, msk);
        check("m0_4to5", last_wdata, 4'd5);
        check("m0_4to5_writes", nwr, 1);

        mode_step(1);
        check("run_editing", editing, 1'b0);
        check("run_mask", blink_mask, 4'd0);
        check("run_t_sel", t_sel, 1'b0);

        mode_step(2);
        inc_timed(1'b0, 6, -1, lat, nwr, msk);
        check("h0_addr", last_waddr, A_H0);
        check("h0_7_wraps", last_wdata, 4'd0);

        preload(2'd3, 4'd1);
        preload(2'd2, 4'd3);
        mode_step(5);
        inc_timed(1'b0, 6, -1, lat, nwr, msk);
        check("h0_3to4", last_wdata, 4'd4);

        preload(2'd3, 4'd2);
        mode_step(4);
        inc_timed(1'b1, 6, -1, lat, nwr, msk);
        check("both_latency", lat, 10);
        check("both_writes", nwr, 1);
        check("both_addr", last_waddr, A_H1);
        check("both_h1_wrap", last_wdata, 4'd0);
        check("both_then_h0", msk, 4'b0100);

        inc_timed(1'b0, 6, 8, lat, nwr, msk);
        check("rst_abort_strobe", lat, -1);
        check("rst_abort_writes", nwr, 0);
        check("rst_abort_editing", editing, 1'b0);
        check("rst_abort_mask", blink_mask, 4'd0);
        check("rst_abort_t_sel", t_sel, 1'b0);
        check("rst_abort_addr", t_address, A_M0);

        mode_step(3);
        preload(2'd1, 4'd4);
        w0 = wr_count;
        inc_timed(1'b0, 65, -1, lat, nwr, msk);
        check("hold_latency", lat, 10);
        check("hold_first", wr_hist[w0 % 8], 4'd5);
`ifdef TSC_AUTOREPEAT_EN
        check("hold_writes", nwr, 3);
        check("hold_second", wr_hist[(w0 + 1) % 8], 4'd0);
        check("hold_third", wr_hist[(w0 + 2) % 8], 4'd1);
`else
        check("hold_writes", nwr, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven time-setting controller for the HH:MM timer block; it drives that block's CPU interface (sel, address, data_in, write_en) and reads its data_out.
- Two buttons, MODE and INC, step through the digits HOUR1, HOUR0, MIN1 and MIN0, and increment the selected digit with per-digit wrap limits.
- Exports an edit/blink mask for the display driver.
- Sits between the board buttons and the timer, sharing the timer bus port; the CPU must not write the timer while `editing` is 1.

Parameters:
- DEB_CYCLES, 1000000: stable-level cycles required to accept a button edge (20 ms at 50 MHz).
- BLINK_CYCLES, 12500000: half-period of the blink toggle for the edited digit.
- REPEAT_CYCLES, 25000000: INC hold time per auto-repeat step (only with TSC_AUTOREPEAT_EN).

Ports:
- clk, input, 1: system clock. One clock; reset is synchronous and active-high.
- rst, input, 1: synchronous active-high reset.
- btn_mode, input, 1: raw MODE button, active-high, asynchronous.
- btn_inc, input, 1: raw INC button, active-high, asynchronous.
- t_sel, output, 1: timer bus select.
- t_address, output, 11: timer register address (`HOUR1`/`HOUR0`/`MIN1`/`MIN0` from xdefs.vh).
- t_wdata, output, 4: write data to timer data_in.
- t_write_en, output, 1: timer write strobe.
- t_rdata, input, 4: timer data_out (registered, valid 1 cycle after the address is presented).
- editing, output, 1: high while in any edit state.
- blink_mask, output, 4: one-hot digit being edited [3]=HOUR1 .. [0]=MIN0, gated by the blink phase; 0 in RUN.

Behaviour:
- Reset values: t_sel=0, t_write_en=0, t_wdata=0, t_address=`MIN0`, editing=0, blink_mask=0, FSM=RUN, blink phase=1, debounce and repeat counters=0.
- Input conditioning (per button):
  - 2-flop synchronizer, then a debounce counter.
  - The accepted level changes only after DEB_CYCLES consecutive cycles at the new level.
  - A press is a one-cycle pulse on an accepted 0->1 transition.
- Main FSM: RUN -> E_H1 -> E_H0 -> E_M1 -> E_M0 -> RUN, advancing one step per MODE press.
  - Entering E_H1 sets editing=1 on the next cycle.
  - Returning to RUN clears editing and blink_mask on the next cycle.
- INC press in an edit state starts the access sub-FSM: ADDR -> WAIT -> CAP -> WR -> back to idle.
  - ADDR: drive t_address = digit address, t_sel=1.
  - WAIT: one cycle, covering the timer's registered read.
  - CAP: latch t_rdata and compute next = (cur >= LIMIT) ? 0 : cur+1.
  - WR: t_write_en=1 and t_sel=1 for exactly one cycle, t_wdata=next.
  - Total INC latency: write strobe asserted 4 cycles after the press pulse.
- Digit limits:
  - HOUR1 = 2; MIN1 = 5; MIN0 = 9.
  - HOUR0 = 3 if the cached hour1 is 2, else 9.
  - Out-of-range reads (e.g. hour0=7 with hour1=2) wrap to 0.
- hour1 cache: updated on every HOUR1 capture/write and captured on E_H0 entry through one automatic read (ADDR/WAIT/CAP, no write).
- Boundaries:
  - A MODE press during an active access is held pending and applied after WR completes.
  - An INC press during an active access is dropped.
  - Simultaneous MODE and INC presses in the same cycle: INC is processed for the current digit, then MODE.
  - t_write_en is never asserted outside WR.
  - t_sel=0 in RUN and in the idle edit sub-state.
- Blink: counter toggles the phase every BLINK_CYCLES while editing and restarts at phase=1 on each digit change. blink_mask = onehot(digit) & {4{phase}}.
- rst mid-access aborts immediately: no write strobe in the following cycle, state returns to RUN.

Optional Feature:
- TSC_AUTOREPEAT_EN defined:
  - Holding the accepted INC level for REPEAT_CYCLES issues a further INC access, then repeats every REPEAT_CYCLES until release.
  - The repeat counter clears on release and on any MODE press.
- Not defined: exactly one increment per accepted press; REPEAT_CYCLES is unused.

Test Plan:
- Common bench parameters: DEB_CYCLES=4, BLINK_CYCLES=8, REPEAT_CYCLES=20.
- Reset, then idle 50 cycles -> editing=0, blink_mask=0, t_sel=0, t_write_en never 1.
- MODE pulse held 3 cycles (bounce) -> no state change; held 6 cycles -> editing=1, blink_mask toggles between 4'b1000 and 0 every 8 cycles.
- E_M0, timer min0=9, INC -> exactly one write cycle with t_address=`MIN0`, t_wdata=0, 4 cycles after the press pulse; min0=4 -> t_wdata=5.
- Timer hour1=2 and hour0=7; enter E_H0 and INC -> t_wdata=0. With hour1=1, hour0=3 -> t_wdata=4.
- MODE and INC in the same cycle in E_H1 with hour1=2 -> write hour1=0, then the FSM is in E_H0. Assert rst during WAIT -> no t_write_en, state RUN.
- With TSC_AUTOREPEAT_EN: hold INC for 65 cycles in E_M1 starting at min1=4 -> writes 5, 0, 0+1=1 (three accesses); without the macro -> single write of 5.
